// File: rtl/ready_mask.sv
// Builds the per-entry ready mask: Count ones rotated left from the read address, with wrap.
module ready_mask #(
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 2 ** BufferWidth
) (
  input  logic [BufferWidth-1:0] R_Addr,
  input  logic [BufferWidth:0]   Count,
  output logic [BufferSize-1:0]  Ready
);

  logic [BufferWidth-1:0] offset;

  // An entry is ready when its distance ahead of the read address is below the unread count;
  // the modulo wraps for free in BufferWidth bits because BufferSize is a power of two.
  always_comb begin
    Ready  = '0;
    offset = '0;
    for (int i = 0; i < BufferSize; i++) begin
      offset   = BufferWidth'(i) - R_Addr;
      Ready[i] = ({1'b0, offset} < Count);
    end
  end

endmodule

// File: rtl/buffer_ready_tracker.sv
// Tracks occupancy of a circular buffer with write/read pointers one bit wider than the address,
// accepting single-entry pushes and multi-entry pops, and flagging pops that ask for too much.
module buffer_ready_tracker #(
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 2 ** BufferWidth
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Push_En,
  input  logic                   Pop_En,
  input  logic [BufferWidth:0]   Pop_Num,
  output logic                   Push_Accept,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic [BufferWidth:0]   Count,
  output logic [BufferSize-1:0]  Ready,
  output logic                   Full,
  output logic                   Empty,
  output logic                   Pop_Err
);

  localparam int PtrWidth = BufferWidth + 1;

  // The pointer scheme only works for power-of-two depths, so refuse anything else outright.
  if (BufferSize != 2 ** BufferWidth) begin : g_bad_size
    $error("buffer_ready_tracker: BufferSize must equal 2**BufferWidth");
  end

  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;
  logic [PtrWidth-1:0] count;
  logic [PtrWidth-1:0] pop_amount;
  logic [PtrWidth-1:0] count_after_pop;
  logic                pop_valid;
  logic                push_accept;

  // Decide pop validity against the pre-edge count only, then see if a push still fits
  // once the popped entries are released; a same-cycle push never helps a pop.
  always_comb begin
    count           = wptr - rptr;
    pop_valid       = Pop_En && (Pop_Num <= count);
    pop_amount      = pop_valid ? Pop_Num : '0;
    count_after_pop = count - pop_amount;
    push_accept     = !Rst && Push_En && (count_after_pop < PtrWidth'(BufferSize));
  end

  // Advance pointers on accepted traffic and register a one-cycle error pulse for rejected pops.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr    <= '0;
      rptr    <= '0;
      Pop_Err <= 1'b0;
    end else begin
      wptr    <= wptr + PtrWidth'(push_accept);
      rptr    <= rptr + pop_amount;
      Pop_Err <= Pop_En && !pop_valid;
    end
  end

  ready_mask #(
    .BufferWidth(BufferWidth),
    .BufferSize (BufferSize)
  ) u_ready_mask (
    .R_Addr(R_Addr),
    .Count (Count),
    .Ready (Ready)
  );

  assign Push_Accept = push_accept;
  assign W_Addr      = wptr[BufferWidth-1:0];
  assign R_Addr      = rptr[BufferWidth-1:0];
  assign Round       = wptr[BufferWidth] ^ rptr[BufferWidth];
  assign Count       = count;
  assign Full        = (count == PtrWidth'(BufferSize));
  assign Empty       = (count == '0);

endmodule

// File: tb/tb_buffer_ready_tracker.sv
// Directed bench for buffer_ready_tracker at BufferWidth=2 with hand-computed expectations.
module tb_buffer_ready_tracker;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Push_En;
  logic       Pop_En;
  logic [2:0] Pop_Num;
  logic       Push_Accept;
  logic [1:0] W_Addr;
  logic [1:0] R_Addr;
  logic       Round;
  logic [2:0] Count;
  logic [3:0] Ready;
  logic       Full;
  logic       Empty;
  logic       Pop_Err;

  int   vectorCount = 0;
  int   missCount   = 0;
  logic lastAccept;

  buffer_ready_tracker #(.BufferWidth(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Push_En    (Push_En),
    .Pop_En     (Pop_En),
    .Pop_Num    (Pop_Num),
    .Push_Accept(Push_Accept),
    .W_Addr     (W_Addr),
    .R_Addr     (R_Addr),
    .Round      (Round),
    .Count      (Count),
    .Ready      (Ready),
    .Full       (Full),
    .Empty      (Empty),
    .Pop_Err    (Pop_Err)
  );

  // 10-unit clock.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, samples the combinational accept mid-cycle, then
  // returns 1 unit after the edge with inputs idled.
  task automatic applyStimulus(input logic rst, input logic push, input logic pop, input logic [2:0] num);
    Rst     = rst;
    Push_En = push;
    Pop_En  = pop;
    Pop_Num = num;
    #2;
    lastAccept = Push_Accept;
    @(posedge Clk);
    #1;
    Rst     = 1'b0;
    Push_En = 1'b0;
    Pop_En  = 1'b0;
    Pop_Num = 3'd0;
  endtask

  task automatic checkState(input string tag, input logic [1:0] w, input logic [1:0] r, input logic rnd,
                            input logic [2:0] cnt, input logic [3:0] rdy, input logic err);
    checkOutput({tag, ".w_addr"}, 32'(W_Addr), 32'(w));
    checkOutput({tag, ".r_addr"}, 32'(R_Addr), 32'(r));
    checkOutput({tag, ".round"},  32'(Round),  32'(rnd));
    checkOutput({tag, ".count"},  32'(Count),  32'(cnt));
    checkOutput({tag, ".ready"},  32'(Ready),  32'(rdy));
    checkOutput({tag, ".full"},   32'(Full),   32'(cnt == 3'd4));
    checkOutput({tag, ".empty"},  32'(Empty),  32'(cnt == 3'd0));
    checkOutput({tag, ".pop_err"}, 32'(Pop_Err), 32'(err));
  endtask

  initial begin
    Rst = 1'b1; Push_En = 1'b0; Pop_En = 1'b0; Pop_Num = 3'd0;

    // Reset with traffic pending; accept must stay low while in reset.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd1);
    checkOutput("rst_accept", 32'(lastAccept), 32'd0);
    checkState("after_rst", 2'd0, 2'd0, 1'b0, 3'd0, 4'b0000, 1'b0);

    // Fill with four pushes.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
      checkOutput($sformatf("fill_accept%0d", i), 32'(lastAccept), 32'd1);
    end
    checkState("full", 2'd0, 2'd0, 1'b1, 3'd4, 4'b1111, 1'b0);

    // Fifth push is refused.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkOutput("overfill_accept", 32'(lastAccept), 32'd0);
    checkState("overfill", 2'd0, 2'd0, 1'b1, 3'd4, 4'b1111, 1'b0);

    // Pop 3, then push 2.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    checkState("pop3", 2'd0, 2'd3, 1'b1, 3'd1, 4'b1000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkState("push2", 2'd2, 2'd3, 1'b1, 3'd3, 4'b1011, 1'b0);

    // Pop 1 to reach Count=2, then an over-sized pop is rejected for one cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1);
    checkState("count2", 2'd2, 2'd0, 1'b0, 3'd2, 4'b0011, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    checkState("bad_pop", 2'd2, 2'd0, 1'b0, 3'd2, 4'b0011, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    checkState("err_clears", 2'd2, 2'd0, 1'b0, 3'd2, 4'b0011, 1'b0);

    // Refill, then push and pop 1 together while full.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkState("refull", 2'd0, 2'd0, 1'b1, 3'd4, 4'b1111, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1);
    checkOutput("full_pushpop_accept", 32'(lastAccept), 32'd1);
    checkState("full_pushpop", 2'd1, 2'd1, 1'b1, 3'd4, 4'b1111, 1'b0);

    // Drain completely with a single pop of 4.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4);
    checkState("drained", 2'd1, 2'd1, 1'b0, 3'd0, 4'b0000, 1'b0);

    // Push and pop together while empty: the pop cannot see the push.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1);
    checkOutput("empty_pushpop_accept", 32'(lastAccept), 32'd1);
    checkState("empty_pushpop", 2'd2, 2'd1, 1'b0, 3'd1, 4'b0010, 1'b1);

    // Pop of zero entries is a valid no-op.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
    checkState("pop_zero", 2'd2, 2'd1, 1'b0, 3'd1, 4'b0010, 1'b0);

    // Reach Count=3, then reset with push and pop pending.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkState("count3", 2'd0, 2'd1, 1'b1, 3'd3, 4'b1110, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd1);
    checkOutput("rst2_accept", 32'(lastAccept), 32'd0);
    checkState("after_rst2", 2'd0, 2'd0, 1'b0, 3'd0, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/buffer_ready_tracker.md
BUFFER_READY_TRACKER -- requirements
Module: buffer_ready_tracker

Interface
REQ-001 SHALL have parameter BufferWidth, default 2, meaning log2 of entry count.
REQ-002 SHALL have parameter BufferSize, default 2**BufferWidth, meaning entry count; other values SHALL fail elaboration.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Push_En  input  1  request to write one entry.
REQ-006 SHALL have port Pop_En  input  1  request to release Pop_Num entries.
REQ-007 SHALL have port Pop_Num  input  BufferWidth+1  entries to release (0..BufferSize).
REQ-008 SHALL have port Push_Accept  output  1  combinational; push accepted this cycle.
REQ-009 SHALL have port W_Addr  output  BufferWidth  next entry to be written.
REQ-010 SHALL have port R_Addr  output  BufferWidth  oldest unread entry.
REQ-011 SHALL have port Round  output  1  write pointer has wrapped once more than read pointer.
REQ-012 SHALL have port Count  output  BufferWidth+1  unread entries, 0..BufferSize.
REQ-013 SHALL have port Ready  output  BufferSize  bit i set iff entry i holds unread data.
REQ-014 SHALL have ports Full, Empty  output  1 each  Count==BufferSize, Count==0.
REQ-015 SHALL have port Pop_Err  output  1  registered one-cycle pulse: rejected pop.

Function
REQ-016 SHALL keep write and read pointers of BufferWidth+1 bits; W_Addr/R_Addr are low bits; Round = XOR of pointer MSBs.
REQ-017 SHALL compute Count = (wptr - rptr) modulo 2**(BufferWidth+1).
REQ-018 SHALL set Ready[i] iff ((i - R_Addr) mod BufferSize) < Count, i.e. Count ones rotated-left from R_Addr with wrap; Count==BufferSize gives all ones for any R_Addr.
REQ-019 SHALL derive Ready, Count, Full, Empty, Round, W_Addr, R_Addr combinationally from pointer registers only; no extra latency after the updating edge.
REQ-020 SHALL treat a pop as valid iff Pop_En and Pop_Num <= pre-edge Count; valid pop advances rptr by Pop_Num (Pop_Num 0 is a valid no-op).
REQ-021 SHALL reject an invalid pop entirely (rptr unchanged) and assert Pop_Err for the cycle after the edge.
REQ-022 SHALL set Push_Accept = Push_En and (Count - valid-pop amount) < BufferSize; accepted push advances wptr by 1.
REQ-023 SHALL permit simultaneous push and pop, including push while Full when a valid pop of >=1 occurs the same cycle.
REQ-024 SHALL never count a same-cycle push toward pop validity (no bypass).
REQ-025 SHALL wrap pointers modulo 2**(BufferWidth+1) with no saturation.

Reset
REQ-026 SHALL, when Rst is high at an edge, clear both pointers and Pop_Err regardless of Push_En/Pop_En.
REQ-027 SHALL after reset present W_Addr=0, R_Addr=0, Round=0, Count=0, Ready=0, Empty=1, Full=0, Pop_Err=0.
REQ-028 SHALL hold Push_Accept at 0 while Rst is high.

Structure
REQ-029 SHALL keep no typedefs in a shared package; BufferWidth default and derived widths are module parameters.
REQ-030 SHALL implement the mask of REQ-018 in one combinational sub-module ready_mask (inputs R_Addr, Count; output Ready), instantiated once.

Verification (BufferWidth=2)
REQ-031 SHALL cover: reset, 4 pushes -> Count=4, Full=1, Ready=1111, Round=1, W_Addr=0; 5th push -> Push_Accept=0.
REQ-032 SHALL cover: from full, pop 3 then push 2 -> R_Addr=3, W_Addr=2, Count=3, Ready=1011 (bits 3,0,1), Round=1.
REQ-033 SHALL cover: Count=2, Pop_Num=3 -> Pop_Err pulses 1 cycle, pointers unchanged, Ready unchanged.
REQ-034 SHALL cover: Full with push + pop 1 same cycle -> Push_Accept=1, Count stays 4, R_Addr and W_Addr each advance by 1.
REQ-035 SHALL cover: Empty with push + pop 1 same cycle -> Pop_Err=1, Count=1 after edge.
REQ-036 SHALL cover: Rst asserted with Count=3 and push+pop pending -> next cycle all outputs at REQ-027 values.
